sd_cmd_engine: RTL

Parametrised SD-bus CMD-line engine for the host controller. It serialises a 48-bit command frame with a generated CRC7 onto the CMD line, then releases the line. It then optionally receives a short (48-bit) or long (136-bit) response, checking CRC7, index, end bit and timeout. All logic runs on the host clock; SD bit timing comes from a one-cycle tick strobe produced by the clock-divider block.

---
 rtl/sd_cmd_engine.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_engine.sv
// SD-bus CMD-line engine: serialises a 48-bit command with CRC7, then optionally
// receives and checks a 48-bit or 136-bit response. Line timing comes from iSD_tick.
module sd_cmd_engine #(
  parameter int TIMEOUT_WIDTH = 8,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic         iClock_host,
  input  logic         iReset,
  input  logic         iSD_tick,
  input  logic         iNew_command,
  input  logic [31:0]  iCmd_argument,
  input  logic [5:0]   iCmd_index,
  input  logic [1:0]   iResp_type,
  input  logic         iTimeout_enable,
  input  logic         iSerial_from_card,
  output logic         oSerial_to_card,
  output logic         oCmd_oe,
  output logic         oBusy,
  output logic         oCommand_complete,
  output logic         oCommand_index_error,
  output logic         oCrc_error,
  output logic         oTimeout_error,
  output logic [135:0] oResponse
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEND    = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_RECEIVE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [1:0] RESP_NONE    = 2'b00;
  localparam logic [1:0] RESP_SHORT   = 2'b01;
  localparam logic [1:0] RESP_LONG    = 2'b10;
  localparam logic [1:0] RESP_NOCHECK = 2'b11;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_TICKS);

  logic [2:0]               state;
  logic [39:0]              header;
  logic [6:0]               crc;
  logic [5:0]               tx_count;
  logic [7:0]               rx_count;
  logic [TIMEOUT_WIDTH-1:0] wait_count;
  logic [5:0]               cmd_index;
  logic [1:0]               resp_type;
  logic                     timeout_en;

  // One step of the serial CRC7 (x^7 + x^3 + 1), MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  logic [135:0]             resp_shift;
  logic [6:0]               crc_tx_next;
  logic [6:0]               crc_rx_next;
  logic [TIMEOUT_WIDTH-1:0] wait_next;
  logic                     rx_last;
  logic                     rx_in_crc;
  logic                     rx_check;
  logic                     rx_index_bad;

  assign resp_shift  = {oResponse[134:0], iSerial_from_card};
  assign crc_tx_next = crc7_step(crc, header[39]);
  assign crc_rx_next = crc7_step(crc, iSerial_from_card);
  assign wait_next   = wait_count + TIMEOUT_WIDTH'(1);
  assign rx_last     = rx_count == ((resp_type == RESP_LONG) ? 8'd135 : 8'd47);
  // Long responses exclude the 8-bit start/reserved prefix from the CRC.
  assign rx_in_crc   = (resp_type == RESP_LONG) ? (rx_count >= 8'd8 && rx_count < 8'd128)
                                                : (rx_count < 8'd40);
  assign rx_check    = resp_type != RESP_NOCHECK;
  assign rx_index_bad = (resp_type == RESP_SHORT) ? (resp_shift[45:40] != cmd_index)
                                                  : (resp_shift[133:128] != 6'h3F);

  assign oCommand_complete = state == ST_DONE;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge iClock_host) begin
    if (iReset) begin
      state                <= ST_IDLE;
      header               <= '0;
      crc                  <= '0;
      tx_count             <= '0;
      rx_count             <= '0;
      wait_count           <= '0;
      cmd_index            <= '0;
      resp_type            <= RESP_NONE;
      timeout_en           <= 1'b0;
      oSerial_to_card      <= 1'b1;
      oCmd_oe              <= 1'b0;
      oBusy                <= 1'b0;
      oCommand_index_error <= 1'b0;
      oCrc_error           <= 1'b0;
      oTimeout_error       <= 1'b0;
      oResponse            <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iNew_command) begin
            header               <= {2'b01, iCmd_index, iCmd_argument};
            cmd_index            <= iCmd_index;
            resp_type            <= iResp_type;
            timeout_en           <= iTimeout_enable;
            crc                  <= '0;
            tx_count             <= '0;
            oCommand_index_error <= 1'b0;
            oCrc_error           <= 1'b0;
            oTimeout_error       <= 1'b0;
            oResponse            <= '0;
            oBusy                <= 1'b1;
            state                <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (iSD_tick) begin
            if (tx_count == 6'd48) begin
              // End bit has been held for a full period; release the line.
              oCmd_oe         <= 1'b0;
              oSerial_to_card <= 1'b1;
              crc             <= '0;
              rx_count        <= '0;
              wait_count      <= '0;
              state           <= (resp_type == RESP_NONE) ? ST_DONE : ST_WAIT;
            end else begin
              oCmd_oe  <= 1'b1;
              tx_count <= tx_count + 6'd1;
              if (tx_count < 6'd40) begin
                oSerial_to_card <= header[39];
                header          <= {header[38:0], 1'b0};
                crc             <= crc_tx_next;
              end else if (tx_count < 6'd47) begin
                oSerial_to_card <= crc[6];
                crc             <= {crc[5:0], 1'b0};
              end else begin
                oSerial_to_card <= 1'b1;
              end
            end
          end
        end

        ST_WAIT: begin
          if (iSD_tick) begin
            if (!iSerial_from_card) begin
              // Start bit is frame bit 0; it wins over a same-tick timeout.
              oResponse <= resp_shift;
              rx_count  <= 8'd1;
              if (rx_in_crc) crc <= crc_rx_next;
              state     <= ST_RECEIVE;
            end else begin
              wait_count <= wait_next;
              if (timeout_en && wait_next == TIMEOUT_LIMIT) begin
                oTimeout_error <= 1'b1;
                state          <= ST_DONE;
              end
            end
          end
        end

        ST_RECEIVE: begin
          if (iSD_tick) begin
            oResponse <= resp_shift;
            rx_count  <= rx_count + 8'd1;
            if (rx_in_crc) crc <= crc_rx_next;
            if (rx_last) begin
              oCommand_index_error <= rx_check && rx_index_bad;
              oCrc_error           <= !iSerial_from_card ||
                                      (rx_check && crc != resp_shift[7:1]);
              state                <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          oBusy <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
